// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings and byte-lane helpers used by the bus masters.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // Copy right-justified write data into every lane the transfer could address.
    function automatic logic [31:0] ahb_lane_replicate(input logic [31:0] data,
                                                       input logic [2:0]  size);
        logic [31:0] res;
        case (size)
            HSIZE_BYTE:  res = {4{data[7:0]}};
            HSIZE_HWORD: res = {2{data[15:0]}};
            default:     res = data;
        endcase
        return res;
    endfunction

    // Right-justify and zero-extend the addressed lanes of a read data word.
    function automatic logic [31:0] ahb_lane_extract(input logic [31:0] data,
                                                     input logic [1:0]  addr,
                                                     input logic [2:0]  size);
        logic [31:0] sh;
        logic [31:0] res;
        sh = data >> {addr, 3'b000};
        case (size)
            HSIZE_BYTE:  res = {24'h0, sh[7:0]};
            HSIZE_HWORD: res = {16'h0, sh[15:0]};
            default:     res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ahb3lite_cmd_master.sv
// Single-outstanding AHB3-lite master: one SINGLE transfer per valid/ready command,
// with a registered valid/ready response carrying read data, error and wait count.
module ahb3lite_cmd_master
    import ahb3lite_pkg::*;
#(
    parameter int unsigned WAITW = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_WRITE,
    input  logic [31:0]      CMD_ADDR,
    input  logic [31:0]      CMD_WDATA,
    input  logic [2:0]       CMD_SIZE,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [31:0]      RSP_RDATA,
    output logic             RSP_ERR,
    output logic [WAITW-1:0] RSP_WAIT,
    output logic [31:0]      HADDR,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic [1:0]       HTRANS,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e           state_q;
    logic [31:0]      haddr_q;
    logic             hwrite_q;
    logic [2:0]       hsize_q;
    logic [1:0]       htrans_q;
    logic [31:0]      hwdata_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;
    logic [WAITW-1:0] rsp_wait_q;

    logic cmd_illegal;
    logic wait_sat;

    assign cmd_illegal = (CMD_SIZE > HSIZE_WORD) ||
                         ((CMD_SIZE == HSIZE_HWORD) && CMD_ADDR[0]) ||
                         ((CMD_SIZE == HSIZE_WORD) && (CMD_ADDR[1:0] != 2'b00));
    assign wait_sat    = &rsp_wait_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_BYTE;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_wait_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (CMD_VALID) begin
                        rsp_wait_q  <= '0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (cmd_illegal) begin
                            // Rejected locally: answer without touching the bus.
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            haddr_q  <= CMD_ADDR;
                            hwrite_q <= CMD_WRITE;
                            hsize_q  <= CMD_SIZE;
                            htrans_q <= HTRANS_NONSEQ;
                            hwdata_q <= CMD_WRITE ? ahb_lane_replicate(CMD_WDATA, CMD_SIZE)
                                                  : '0;
                            state_q  <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        state_q  <= StData;
                    end else if (!wait_sat) begin
                        rsp_wait_q <= rsp_wait_q + {{(WAITW-1){1'b0}}, 1'b1};
                    end
                end
                StData: begin
                    // First ERROR cycle arrives with HREADY low and simply waits here.
                    if (HREADY) begin
                        rsp_err_q   <= (HRESP == HRESP_ERROR);
                        rsp_rdata_q <= hwrite_q ? '0
                                                : ahb_lane_extract(HRDATA, haddr_q[1:0], hsize_q);
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (!wait_sat) begin
                        rsp_wait_q <= rsp_wait_q + {{(WAITW-1){1'b0}}, 1'b1};
                    end
                end
                StResp: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign CMD_READY = RESETn && (state_q == StIdle);

    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HTRANS    = htrans_q;
    assign HWDATA    = hwdata_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_WAIT  = rsp_wait_q;

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Directed bench for ahb3lite_cmd_master; the bench plays the AHB slave by hand.
module tb_ahb3lite_cmd_master;

    localparam int unsigned WAITW = 3;

    logic             CLK = 1'b0;
    logic             RESETn;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic             CMD_WRITE;
    logic [31:0]      CMD_ADDR;
    logic [31:0]      CMD_WDATA;
    logic [2:0]       CMD_SIZE;
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [31:0]      RSP_RDATA;
    logic             RSP_ERR;
    logic [WAITW-1:0] RSP_WAIT;
    logic [31:0]      HADDR;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic [1:0]       HTRANS;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;

    int total = 0;
    int bad   = 0;

    ahb3lite_cmd_master #(.WAITW(WAITW)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WRITE (CMD_WRITE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .CMD_SIZE  (CMD_SIZE),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .RSP_WAIT  (RSP_WAIT),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Present one command at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s);
        chk("cmd_ready_before", 32'(CMD_READY), 32'h1);
        CMD_VALID = 1'b1;
        CMD_WRITE = w;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        CMD_SIZE  = s;
        cyc();
        CMD_VALID = 1'b0;
    endtask

    task automatic take_rsp();
        RSP_READY = 1'b1;
        cyc();
        RSP_READY = 1'b0;
        chk("rsp_dropped", 32'(RSP_VALID), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn    = 1'b0;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        CMD_SIZE  = '0;
        RSP_READY = 1'b0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        #3;
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hburst", 32'(HBURST), 32'h0);
        chk("rst_hprot", 32'(HPROT), 32'h3);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_cmd_ready", 32'(CMD_READY), 32'h0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rst_rsp_wait", 32'(RSP_WAIT), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("idle_cmd_ready", 32'(CMD_READY), 32'h1);

        // Zero-wait word write
        issue(1'b1, 32'h4, 32'hCAFEF00D, 3'd2);
        chk("w_htrans", 32'(HTRANS), 32'h2);
        chk("w_haddr", HADDR, 32'h4);
        chk("w_hwrite", 32'(HWRITE), 32'h1);
        chk("w_hsize", 32'(HSIZE), 32'h2);
        chk("w_cmd_ready", 32'(CMD_READY), 32'h0);
        cyc();
        chk("w_htrans_data", 32'(HTRANS), 32'h0);
        chk("w_hwdata", HWDATA, 32'hCAFEF00D);
        chk("w_rsp_early", 32'(RSP_VALID), 32'h0);
        cyc();
        chk("w_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("w_rsp_err", 32'(RSP_ERR), 32'h0);
        chk("w_rsp_wait", 32'(RSP_WAIT), 32'h0);
        chk("w_rsp_rdata", RSP_RDATA, 32'h0);
        take_rsp();
        chk("w_cmd_ready_after", 32'(CMD_READY), 32'h1);

        // Byte read at 0x7 picks the top lane
        issue(1'b0, 32'h7, 32'h0, 3'd0);
        chk("br_hsize", 32'(HSIZE), 32'h0);
        chk("br_htrans", 32'(HTRANS), 32'h2);
        HRDATA = 32'hAABBCCDD;
        cyc();
        cyc();
        chk("br_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("br_rdata", RSP_RDATA, 32'h000000AA);
        take_rsp();

        // Halfword write is replicated into both halves
        issue(1'b1, 32'h2, 32'h1234, 3'd1);
        chk("hw_hsize", 32'(HSIZE), 32'h1);
        cyc();
        chk("hw_hwdata", HWDATA, 32'h12341234);
        cyc();
        chk("hw_rsp_valid", 32'(RSP_VALID), 32'h1);
        take_rsp();

        // Word read: 2 wait states in address phase, 3 in data phase
        issue(1'b0, 32'h10, 32'h0, 3'd2);
        HREADY = 1'b0;
        chk("ws_htrans0", 32'(HTRANS), 32'h2);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("ws_addr_hold", HADDR, 32'h10);
            chk("ws_htrans_hold", 32'(HTRANS), 32'h2);
            chk("ws_hsize_hold", 32'(HSIZE), 32'h2);
        end
        HREADY = 1'b1;
        cyc();
        chk("ws_data_htrans", 32'(HTRANS), 32'h0);
        HREADY = 1'b0;
        HRDATA = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ws_rsp_wait_hold", 32'(RSP_VALID), 32'h0);
        end
        HREADY = 1'b1;
        cyc();
        chk("ws_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("ws_rdata", RSP_RDATA, 32'h11223344);
        chk("ws_wait", 32'(RSP_WAIT), 32'h5);
        take_rsp();

        // Two-cycle slave ERROR
        issue(1'b1, 32'h8, 32'h55, 3'd2);
        cyc();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        cyc();
        chk("er_htrans", 32'(HTRANS), 32'h0);
        chk("er_rsp_early", 32'(RSP_VALID), 32'h0);
        HREADY = 1'b1;
        cyc();
        HRESP = 1'b0;
        chk("er_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("er_rsp_err", 32'(RSP_ERR), 32'h1);
        chk("er_rsp_wait", 32'(RSP_WAIT), 32'h1);
        take_rsp();

        // Misaligned halfword: local reject, response held under backpressure
        issue(1'b0, 32'h1, 32'h0, 3'd1);
        chk("mis_htrans", 32'(HTRANS), 32'h0);
        chk("mis_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("mis_rsp_err", 32'(RSP_ERR), 32'h1);
        chk("mis_rsp_wait", 32'(RSP_WAIT), 32'h0);
        CMD_VALID = 1'b1;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = 32'h20;
        CMD_SIZE  = 3'd2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_rsp_valid", 32'(RSP_VALID), 32'h1);
            chk("bp_rsp_err", 32'(RSP_ERR), 32'h1);
            chk("bp_cmd_ready", 32'(CMD_READY), 32'h0);
            chk("bp_htrans", 32'(HTRANS), 32'h0);
        end
        RSP_READY = 1'b1;
        cyc();
        RSP_READY = 1'b0;
        chk("bp_rsp_gone", 32'(RSP_VALID), 32'h0);
        chk("bp_not_taken", 32'(HTRANS), 32'h0);
        chk("bp_cmd_ready_idle", 32'(CMD_READY), 32'h1);
        cyc();
        CMD_VALID = 1'b0;
        chk("bp_next_htrans", 32'(HTRANS), 32'h2);
        chk("bp_next_haddr", HADDR, 32'h20);
        cyc();
        cyc();
        chk("bp_next_rsp", 32'(RSP_VALID), 32'h1);
        chk("bp_next_rdata", RSP_RDATA, 32'h11223344);
        chk("bp_next_err", 32'(RSP_ERR), 32'h0);
        take_rsp();

        // Illegal size and misaligned word are rejected too
        issue(1'b1, 32'h0, 32'h0, 3'd3);
        chk("sz3_htrans", 32'(HTRANS), 32'h0);
        chk("sz3_err", 32'(RSP_ERR), 32'h1);
        take_rsp();
        issue(1'b0, 32'h2, 32'h0, 3'd2);
        chk("misw_htrans", 32'(HTRANS), 32'h0);
        chk("misw_err", 32'(RSP_ERR), 32'h1);
        take_rsp();

        // Wait counter saturates at 2^WAITW-1
        issue(1'b0, 32'h30, 32'h0, 3'd2);
        HREADY = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        HREADY = 1'b1;
        cyc();
        cyc();
        chk("sat_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("sat_wait", 32'(RSP_WAIT), 32'h7);
        take_rsp();

        // Reset during the data phase
        issue(1'b0, 32'h40, 32'h0, 3'd2);
        cyc();
        HREADY = 1'b0;
        cyc();
        #2;
        RESETn = 1'b0;
        #1;
        chk("rr_htrans", 32'(HTRANS), 32'h0);
        chk("rr_haddr", HADDR, 32'h0);
        chk("rr_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rr_cmd_ready", 32'(CMD_READY), 32'h0);
        HREADY = 1'b1;
        @(negedge CLK);
        RESETn = 1'b1;
        cyc();
        chk("rr_idle_ready", 32'(CMD_READY), 32'h1);
        chk("rr_idle_rsp", 32'(RSP_VALID), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
